uart_tx_param: RTL and testbench
================================

# uart_tx_param

Parametrised UART transmitter with an input FIFO. It serialises words onto a single TX line using a configurable frame format: data width, parity mode, stop-bit count and bit period. It sits between a parallel producer, which uses a valid/ready handshake, and the board TX pin. It supersedes the fixed 8N1, ×16 transmitter in designs that need other frame formats or back-to-back streaming.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5–9.
- CLKS_PER_BIT, 16: clock cycles per serial bit; ≥2.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries; power of 2, ≥2.

Ports:
- reset  in  1  asynchronous, active-low reset
- clock  in  1  system clock
- wr_valid  in  1  producer offers wr_data this cycle
- wr_data  in  DATA_BITS  word to transmit
- wr_ready  out  1  FIFO not full; a write is accepted on a clock edge where wr_valid && wr_ready
- tx  out  1  serial line, registered, idle high
- busy  out  1  frame in progress or FIFO non-empty
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH

## Operation
- Reset (reset=0, asynchronous) state:
  - tx=1, busy=0, wr_ready=1, fifo_count=0.
  - FIFO pointers and baud counter = 0; FSM = IDLE.
  - Takes effect immediately, including mid-frame. The aborted frame and all queued words are discarded.
- FIFO:
  - A write when full is ignored and wr_data is dropped; wr_ready is already 0 in that case.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE → START → DATA → PARITY (skipped when PARITY=0) → STOP → IDLE or START.
  - IDLE: tx=1, baud counter held at 0. If FIFO non-empty: pop the head word into the shift register, go to START.
  - START: tx=0 for one bit period.
  - DATA: shift out DATA_BITS bits, LSB first, one per bit period.
  - PARITY: odd parity makes the total count of ones (data + parity) odd; even parity makes it even.
  - STOP: tx=1 for STOP_BITS bit periods.
  - End of the last stop bit: if FIFO non-empty, pop and go directly to START with no idle cycle; else go to IDLE.
- Baud counter runs only outside IDLE. It counts 0..CLKS_PER_BIT-1, and the FSM advances when it wraps. It restarts at 0 on every START entry, so there is no phase dependence on a free-running counter.
- busy = (state≠IDLE) || (fifo_count≠0).

## Timing
- Write accepted at edge N, FIFO empty, FSM idle:
  - fifo_count=1 after edge N.
  - Pop at edge N+1; tx falls to 0 after edge N+1.
- Every bit, including start, parity and stop bits, lasts exactly CLKS_PER_BIT cycles.
- Frame length F = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- Back-to-back words: consecutive start bits are exactly F cycles apart.
- wr_ready and fifo_count are registered-state derived; they update the cycle after a push or pop.
- The word being shifted is held in the shift register. A FIFO write during transmission cannot corrupt the current frame.
- Reset deassertion: first accepted write at the first rising edge with reset=1.

## Test plan
- 8N1, CLKS_PER_BIT=16, write 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 16 cycles. Start bit begins 1 cycle after acceptance. busy=0 160 cycles after the start-bit edge.
- PARITY=2 (even), write 0x07 → parity bit 1. PARITY=1 (odd), write 0x07 → parity bit 0. Frame = 11 bit periods.
- FIFO_DEPTH=4, hold wr_valid for 6 cycles with tx stalled by an in-progress frame:
  - fifo_count saturates at 4; wr_ready=0.
  - Extra writes are dropped.
  - Exactly 5 frames total appear (1 in flight + 4 queued).
- Stream 3 words 0xA1, 0x3C, 0xFF, 8N1 → start bits at t, t+160, t+320; tx never returns high between the stop bit and the next start bit. Decoded bytes match in order.
- DATA_BITS=7, STOP_BITS=2, CLKS_PER_BIT=4, write 0x7F → frame 0, seven 1s, 1, 1 (40 cycles); bit 7 of the input is ignored.
- Assert reset during the DATA bit 3 of a frame with 2 words queued:
  - tx=1 and fifo_count=0 immediately.
  - After release: no output until a new write; the next frame is correct.

Source files
------------

// File: rtl/uart_tx_param.sv
// UART transmitter with a small input FIFO and a compile-time frame format
// (data width, parity, stop bits, bit period). Words are sent LSB first.
//
// state    | meaning
// ---------+---------------------------------------------------------
// S_IDLE   | line high, baud counter parked at 0, waiting for a word
// S_START  | start bit (tx=0)
// S_DATA   | data bits, LSB first, bit_q counts the bit in flight
// S_PARITY | parity bit (only reachable when PARITY != 0)
// S_STOP   | stop bit(s), bit_q counts the stop bit in flight
module uart_tx_param #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          reset,
    input  logic                          clock,
    input  logic                          wr_valid,
    input  logic [DATA_BITS-1:0]          wr_data,
    output logic                          wr_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 push, pop;
    logic                 fifo_nonempty;
    logic [DATA_BITS-1:0] head;

    state_t               state_q, state_d;
    logic [BW-1:0]        baud_q, baud_d;
    logic [IW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 baud_wrap;

    assign wr_ready      = (count_q != CW'(FIFO_DEPTH));
    assign push          = wr_valid && wr_ready;
    assign fifo_nonempty = (count_q != '0);
    assign head          = mem_q[rd_ptr_q];
    assign baud_wrap     = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
        end
    end

    // Every exit from IDLE or STOP lands with baud_d = 0, so each frame starts phase-aligned.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        if (state_q != S_IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_wrap) begin
                    state_d = S_DATA;
                    bit_d   = '0;
                end
            end
            S_DATA: begin
                if (baud_wrap) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == IW'(DATA_BITS - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_wrap) begin
                    state_d = S_STOP;
                    bit_d   = '0;
                end
            end
            S_STOP: begin
                if (baud_wrap) begin
                    if (bit_q == IW'(STOP_BITS - 1)) begin
                        bit_d = '0;
                        if (fifo_nonempty) begin
                            pop     = 1'b1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            shift_d  = head;
            parity_d = (PARITY == 1) ? ~^head : ^head;
        end
    end

    // tx is registered, so it is decoded from the state being entered.
    always_comb begin
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_d;
            default:  tx_d = 1'b1;
        endcase
    end

    assign tx         = tx_q;
    assign busy       = (state_q != S_IDLE) || fifo_nonempty;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four instances cover 8N1/x16, even and odd
// parity, and a 7-bit two-stop-bit format; expected line levels are hand-built.
module tb_uart_tx_param;
    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] wv;
    logic [7:0] wd;
    logic [3:0] tx_w, busy_w, rdy_w;
    logic [2:0] fc0, fc1, fc2, fc3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(16), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) d0 (
        .reset(reset), .clock(clock), .wr_valid(wv[0]), .wr_data(wd),
        .wr_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .fifo_count(fc0));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) d1 (
        .reset(reset), .clock(clock), .wr_valid(wv[1]), .wr_data(wd),
        .wr_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .fifo_count(fc1));
    uart_tx_param #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) d2 (
        .reset(reset), .clock(clock), .wr_valid(wv[2]), .wr_data(wd),
        .wr_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .fifo_count(fc2));
    uart_tx_param #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) d3 (
        .reset(reset), .clock(clock), .wr_valid(wv[3]), .wr_data(wd[6:0]),
        .wr_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .fifo_count(fc3));

    function automatic int fc_of(input int i);
        case (i)
            0:       return int'(fc0);
            1:       return int'(fc1);
            2:       return int'(fc2);
            default: return int'(fc3);
        endcase
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One write, accepted at the next rising edge; returns at the following negedge.
    task automatic push(input int idx, input logic [7:0] d);
        @(negedge clock);
        wd      = d;
        wv[idx] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wv[idx] = 1'b0;
    endtask

    // Called at the negedge just after the start-bit edge; checks every cycle of every bit.
    task automatic check_bits(input int idx, input int clks, input int nbits,
                              input logic [15:0] exp_bits, input string tag);
        int ok;
        for (int k = 0; k < nbits; k++) begin
            ok = 0;
            for (int j = 0; j < clks; j++) begin
                if (tx_w[idx] == exp_bits[k]) ok++;
                @(negedge clock);
            end
            check($sformatf("%s bit%0d", tag, k), ok, clks);
        end
    endtask

    task automatic recv(input int idx, input int clks, input int nd,
                        output int data, output time t_start);
        int waited;
        waited  = 0;
        data    = -1;
        t_start = 0;
        while (tx_w[idx] !== 1'b0 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        check("start seen", int'(tx_w[idx]), 0);
        if (tx_w[idx] !== 1'b0) return;
        t_start = $time;
        repeat (clks / 2) @(negedge clock);
        check("start mid", int'(tx_w[idx]), 0);
        data = 0;
        for (int k = 0; k < nd; k++) begin
            repeat (clks) @(negedge clock);
            if (tx_w[idx]) data = data | (1 << k);
        end
        repeat (clks) @(negedge clock);
        check("stop mid", int'(tx_w[idx]), 1);
    endtask

    task automatic watch_idle(input int idx, input int cycles, input string tag);
        int zeros;
        zeros = 0;
        for (int j = 0; j < cycles; j++) begin
            if (tx_w[idx] == 1'b0) zeros++;
            @(negedge clock);
        end
        check(tag, zeros, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  d;
        time t [3];
        logic [7:0] words [3];

        reset = 1'b0;
        wv    = '0;
        wd    = '0;
        repeat (3) @(negedge clock);
        check("rst tx", int'(tx_w[0]), 1);
        check("rst busy", int'(busy_w[0]), 0);
        check("rst ready", int'(rdy_w[0]), 1);
        check("rst count", fc_of(0), 0);
        check("rst tx d3", int'(tx_w[3]), 1);

        // First write offered right at reset release.
        wd    = 8'h55;
        wv[0] = 1'b1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        wv[0] = 1'b0;
        check("accept count", fc_of(0), 1);
        check("accept tx", int'(tx_w[0]), 1);
        @(negedge clock);
        check("pop count", fc_of(0), 0);
        check("pop busy", int'(busy_w[0]), 1);
        check_bits(0, 16, 10, 16'h02AA, "8n1 55");
        check("8n1 busy end", int'(busy_w[0]), 0);
        check("8n1 tx end", int'(tx_w[0]), 1);

        push(1, 8'h07);
        @(negedge clock);
        check_bits(1, 4, 11, 16'h060E, "even 07");
        check("even busy end", int'(busy_w[1]), 0);

        push(2, 8'h07);
        @(negedge clock);
        check_bits(2, 4, 11, 16'h040E, "odd 07");
        check("odd busy end", int'(busy_w[2]), 0);

        push(3, 8'hFF);
        @(negedge clock);
        check_bits(3, 4, 10, 16'h03FE, "7n2 7f");
        check("7n2 busy end", int'(busy_w[3]), 0);

        // Saturate the FIFO: six consecutive offers, one in flight, four queued, one dropped.
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clock);
                    if (i == 5) begin
                        check("sat count e5", fc_of(0), 4);
                        check("sat ready e5", int'(rdy_w[0]), 0);
                    end
                    wv[0] = 1'b1;
                    wd    = 8'(8'h11 * (i + 1));
                end
                @(negedge clock);
                check("sat count e6", fc_of(0), 4);
                check("sat ready e6", int'(rdy_w[0]), 0);
                wv[0] = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    recv(0, 16, 8, d, t[0]);
                    check($sformatf("sat frame%0d", i), d, 8'h11 * (i + 1));
                end
            end
        join
        watch_idle(0, 100, "sat no 6th frame");
        check("sat busy end", int'(busy_w[0]), 0);

        // Back-to-back stream: start bits exactly one frame (160 cycles) apart.
        words[0] = 8'hA1;
        words[1] = 8'h3C;
        words[2] = 8'hFF;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clock);
                    wv[0] = 1'b1;
                    wd    = words[i];
                end
                @(negedge clock);
                wv[0] = 1'b0;
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    recv(0, 16, 8, d, t[i]);
                    check($sformatf("stream word%0d", i), d, int'(words[i]));
                end
            end
        join
        check("stream gap01", int'(t[1] - t[0]), 1600);
        check("stream gap12", int'(t[2] - t[1]), 1600);
        watch_idle(0, 120, "stream drain");

        // Reset in the middle of data bit 3 with two words queued.
        words[0] = 8'h37;
        words[1] = 8'h5A;
        words[2] = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            wv[0] = 1'b1;
            wd    = words[i];
        end
        @(negedge clock);
        wv[0] = 1'b0;
        repeat (71) @(negedge clock);
        check("pre-rst tx bit3", int'(tx_w[0]), 0);
        check("pre-rst count", fc_of(0), 2);
        #2;
        reset = 1'b0;
        #1;
        check("mid-rst tx", int'(tx_w[0]), 1);
        check("mid-rst count", fc_of(0), 0);
        check("mid-rst busy", int'(busy_w[0]), 0);
        check("mid-rst ready", int'(rdy_w[0]), 1);
        @(negedge clock);
        reset = 1'b1;
        watch_idle(0, 50, "post-rst silent");
        check("post-rst busy", int'(busy_w[0]), 0);
        push(0, 8'hC4);
        @(negedge clock);
        check_bits(0, 16, 10, 16'h0388, "post-rst c4");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
